// File: rtl/load_buffer_if.sv
// Bus bundle between the load buffer and its neighbours: the address-unit enqueue path,
// ROB control, the memory read port and the CDB broadcast.
interface load_buffer_if #(
    parameter int AddressWidth = 32,
    parameter int ROBWidth     = 4,
    parameter int IDWidth      = 6
);
    logic                    addrunit_lbuffer_en_in;
    logic [AddressWidth-1:0] addrunit_lbuffer_a_in;
    logic [ROBWidth-1:0]     addrunit_lbuffer_dest_in;
    logic [IDWidth-1:0]      addrunit_lbuffer_opcode_in;
    logic                    lbuffer_addrunit_full_out;
    logic                    rob_lbuffer_store_clear_in;
    logic                    rob_lbuffer_rst_in;
    logic                    lbuffer_mem_req_out;
    logic [AddressWidth-1:0] lbuffer_mem_a_out;
    logic [1:0]              lbuffer_mem_size_out;
    logic                    mem_lbuffer_ack_in;
    logic [AddressWidth-1:0] mem_lbuffer_data_in;
    logic                    lbuffer_cdb_en_out;
    logic [ROBWidth-1:0]     lbuffer_cdb_dest_out;
    logic [AddressWidth-1:0] lbuffer_cdb_value_out;

    // Handshakes: an enqueue is taken on a rising clk_in edge when en_in is high and
    // full_out is low; mem_req_out stays high with a stable address/size until the
    // one-cycle ack_in pulse; cdb_en_out is a one-cycle valid with no back-pressure.
    modport master (
        input  addrunit_lbuffer_en_in, addrunit_lbuffer_a_in, addrunit_lbuffer_dest_in,
        input  addrunit_lbuffer_opcode_in, rob_lbuffer_store_clear_in, rob_lbuffer_rst_in,
        input  mem_lbuffer_ack_in, mem_lbuffer_data_in,
        output lbuffer_addrunit_full_out, lbuffer_mem_req_out, lbuffer_mem_a_out,
        output lbuffer_mem_size_out, lbuffer_cdb_en_out, lbuffer_cdb_dest_out,
        output lbuffer_cdb_value_out
    );

    modport slave (
        output addrunit_lbuffer_en_in, addrunit_lbuffer_a_in, addrunit_lbuffer_dest_in,
        output addrunit_lbuffer_opcode_in, rob_lbuffer_store_clear_in, rob_lbuffer_rst_in,
        output mem_lbuffer_ack_in, mem_lbuffer_data_in,
        input  lbuffer_addrunit_full_out, lbuffer_mem_req_out, lbuffer_mem_a_out,
        input  lbuffer_mem_size_out, lbuffer_cdb_en_out, lbuffer_cdb_dest_out,
        input  lbuffer_cdb_value_out
    );
endinterface

// File: rtl/load_buffer.sv
// In-order load queue: issues one memory read at a time for the head entry,
// extends the returned data by opcode and broadcasts it with its ROB tag on the CDB.
module load_buffer #(
    parameter int                 DEPTH        = 8,
    parameter int                 AddressWidth = 32,
    parameter int                 ROBWidth     = 4,
    parameter int                 IDWidth      = 6,
    parameter logic [IDWidth-1:0] OP_LB        = IDWidth'(10),
    parameter logic [IDWidth-1:0] OP_LH        = IDWidth'(11),
    parameter logic [IDWidth-1:0] OP_LW        = IDWidth'(12),
    parameter logic [IDWidth-1:0] OP_LBU       = IDWidth'(13),
    parameter logic [IDWidth-1:0] OP_LHU       = IDWidth'(14)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    load_buffer_if.master            bus,
    output logic [1:0]               lbuffer_dbg_state_out,
    output logic [$clog2(DEPTH):0]   lbuffer_dbg_count_out
);
    localparam int         IW = $clog2(DEPTH);
    localparam logic [IW:0] FULL_COUNT = (IW+1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic [AddressWidth-1:0] r_addr_q [DEPTH];
    logic [ROBWidth-1:0]     r_dest_q [DEPTH];
    logic [IDWidth-1:0]      r_op_q   [DEPTH];

    logic [IW-1:0]           r_head;
    logic [IW-1:0]           r_tail;
    logic [IW:0]             r_count;
    logic [1:0]              r_state;
    logic                    r_req;
    logic [AddressWidth-1:0] r_mem_a;
    logic [1:0]              r_mem_size;
    logic                    r_cdb_en;
    logic [ROBWidth-1:0]     r_cdb_dest;
    logic [AddressWidth-1:0] r_cdb_value;

    logic w_full;
    logic w_enq;
    logic w_deq;

    function automatic logic [1:0] size_of(input logic [IDWidth-1:0] op);
        case (op)
            OP_LB, OP_LBU: size_of = SZ_BYTE;
            OP_LH, OP_LHU: size_of = SZ_HALF;
            default:       size_of = SZ_WORD;
        endcase
    endfunction

    function automatic logic [AddressWidth-1:0] extend(input logic [IDWidth-1:0] op,
                                                        input logic [AddressWidth-1:0] d);
        case (op)
            OP_LB:   extend = {{(AddressWidth-8){d[7]}}, d[7:0]};
            OP_LBU:  extend = {{(AddressWidth-8){1'b0}}, d[7:0]};
            OP_LH:   extend = {{(AddressWidth-16){d[15]}}, d[15:0]};
            OP_LHU:  extend = {{(AddressWidth-16){1'b0}}, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    // full is taken from the current count, so a same-cycle dequeue never frees a slot early.
    assign w_full = (r_count == FULL_COUNT);
    assign w_enq  = bus.addrunit_lbuffer_en_in && !w_full && !bus.rob_lbuffer_rst_in;
    assign w_deq  = (r_state == ST_WAIT) && bus.mem_lbuffer_ack_in && !bus.rob_lbuffer_rst_in;

    always_ff @(posedge clk_in) begin
        if (rdy_in && w_enq) begin
            r_addr_q[r_tail] <= bus.addrunit_lbuffer_a_in;
            r_dest_q[r_tail] <= bus.addrunit_lbuffer_dest_in;
            r_op_q[r_tail]   <= bus.addrunit_lbuffer_opcode_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_state     <= ST_IDLE;
            r_req       <= 1'b0;
            r_mem_a     <= '0;
            r_mem_size  <= '0;
            r_cdb_en    <= 1'b0;
            r_cdb_dest  <= '0;
            r_cdb_value <= '0;
        end else if (rdy_in) begin
            r_cdb_en <= 1'b0;
            if (bus.rob_lbuffer_rst_in) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_req   <= 1'b0;
                // An in-flight read must still be absorbed, so WAIT parks in DRAIN until its ack.
                if (r_state != ST_IDLE)
                    r_state <= bus.mem_lbuffer_ack_in ? ST_IDLE : ST_DRAIN;
            end else begin
                if (w_enq)
                    r_tail <= r_tail + 1'b1;
                if (w_deq)
                    r_head <= r_head + 1'b1;
                case ({w_enq, w_deq})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase

                case (r_state)
                    ST_IDLE: begin
                        if ((r_count != '0) && bus.rob_lbuffer_store_clear_in) begin
                            r_req      <= 1'b1;
                            r_mem_a    <= r_addr_q[r_head];
                            r_mem_size <= size_of(r_op_q[r_head]);
                            r_state    <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (bus.mem_lbuffer_ack_in) begin
                            r_req       <= 1'b0;
                            r_cdb_en    <= 1'b1;
                            r_cdb_dest  <= r_dest_q[r_head];
                            r_cdb_value <= extend(r_op_q[r_head], bus.mem_lbuffer_data_in);
                            r_state     <= ST_IDLE;
                        end
                    end
                    ST_DRAIN: begin
                        if (bus.mem_lbuffer_ack_in)
                            r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.lbuffer_addrunit_full_out = w_full;
    assign bus.lbuffer_mem_req_out       = r_req;
    assign bus.lbuffer_mem_a_out         = r_mem_a;
    assign bus.lbuffer_mem_size_out      = r_mem_size;
    assign bus.lbuffer_cdb_en_out        = r_cdb_en;
    assign bus.lbuffer_cdb_dest_out      = r_cdb_dest;
    assign bus.lbuffer_cdb_value_out     = r_cdb_value;
    assign lbuffer_dbg_state_out         = r_state;
    assign lbuffer_dbg_count_out         = r_count;
endmodule

// File: tb/tb_load_buffer.sv
// Directed bench for load_buffer: CDB results are checked in order against an expected queue.
module tb_load_buffer;
    localparam logic [5:0] OP_LB  = 6'd10;
    localparam logic [5:0] OP_LH  = 6'd11;
    localparam logic [5:0] OP_LW  = 6'd12;
    localparam logic [5:0] OP_LBU = 6'd13;
    localparam logic [5:0] OP_LHU = 6'd14;

    logic       clk_in;
    logic       rst_n;
    logic       rdy;
    logic [1:0] dbg_state;
    logic [3:0] dbg_count;

    int total = 0;
    int bad   = 0;
    logic [35:0] exp_q[$];

    load_buffer_if #(.AddressWidth(32), .ROBWidth(4), .IDWidth(6)) lb_if ();

    load_buffer #(
        .DEPTH(8), .AddressWidth(32), .ROBWidth(4), .IDWidth(6),
        .OP_LB(OP_LB), .OP_LH(OP_LH), .OP_LW(OP_LW), .OP_LBU(OP_LBU), .OP_LHU(OP_LHU)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_n),
        .rdy_in(rdy),
        .bus(lb_if),
        .lbuffer_dbg_state_out(dbg_state),
        .lbuffer_dbg_count_out(dbg_count)
    );

    // clock / reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, need finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // scoreboard: every CDB pulse must match the oldest expected {tag, value}
    always @(negedge clk_in) begin
        if (rst_n && lb_if.lbuffer_cdb_en_out) begin
            if (exp_q.size() == 0) begin
                check("cdb_unexpected", 36'd1, 36'd0);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                check("cdb_result", {lb_if.lbuffer_cdb_dest_out, lb_if.lbuffer_cdb_value_out}, e);
            end
        end
    end

    // driver tasks; all start and end 1 time unit after a rising edge
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic enqueue(input logic [31:0] a, input logic [3:0] tag, input logic [5:0] op);
        lb_if.addrunit_lbuffer_en_in     = 1'b1;
        lb_if.addrunit_lbuffer_a_in      = a;
        lb_if.addrunit_lbuffer_dest_in   = tag;
        lb_if.addrunit_lbuffer_opcode_in = op;
        tick();
        lb_if.addrunit_lbuffer_en_in = 1'b0;
    endtask

    task automatic ack(input logic [31:0] data);
        lb_if.mem_lbuffer_ack_in  = 1'b1;
        lb_if.mem_lbuffer_data_in = data;
        tick();
        lb_if.mem_lbuffer_ack_in  = 1'b0;
        lb_if.mem_lbuffer_data_in = '0;
    endtask

    task automatic serve(input logic [31:0] data, input logic [31:0] exp_a, input logic [1:0] exp_sz);
        int n = 0;
        while (!lb_if.lbuffer_mem_req_out && n < 20) begin
            tick();
            n++;
        end
        check("req_seen", {35'd0, lb_if.lbuffer_mem_req_out}, 36'd1);
        check("req_addr", {4'd0, lb_if.lbuffer_mem_a_out}, {4'd0, exp_a});
        check("req_size", {34'd0, lb_if.lbuffer_mem_size_out}, {34'd0, exp_sz});
        ack(data);
        check("req_drop", {35'd0, lb_if.lbuffer_mem_req_out}, 36'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        rdy   = 1'b1;
        lb_if.addrunit_lbuffer_en_in     = 1'b0;
        lb_if.addrunit_lbuffer_a_in      = '0;
        lb_if.addrunit_lbuffer_dest_in   = '0;
        lb_if.addrunit_lbuffer_opcode_in = '0;
        lb_if.rob_lbuffer_store_clear_in = 1'b1;
        lb_if.rob_lbuffer_rst_in         = 1'b0;
        lb_if.mem_lbuffer_ack_in         = 1'b0;
        lb_if.mem_lbuffer_data_in        = '0;
        tick();
        tick();
        check("rst_req",   {35'd0, lb_if.lbuffer_mem_req_out}, 36'd0);
        check("rst_full",  {35'd0, lb_if.lbuffer_addrunit_full_out}, 36'd0);
        check("rst_cdb",   {35'd0, lb_if.lbuffer_cdb_en_out}, 36'd0);
        check("rst_value", {lb_if.lbuffer_cdb_dest_out, lb_if.lbuffer_cdb_value_out}, 36'd0);
        check("rst_state", {34'd0, dbg_state}, 36'd0);
        check("rst_count", {32'd0, dbg_count}, 36'd0);
        rst_n = 1'b1;
        tick();

        // basic LW with an ack three cycles after the request, plus a rdy stall
        enqueue(32'h100, 4'd3, OP_LW);
        check("lw_req_early", {35'd0, lb_if.lbuffer_mem_req_out}, 36'd0);
        tick();
        check("lw_req_up", {35'd0, lb_if.lbuffer_mem_req_out}, 36'd1);
        rdy = 1'b0;
        tick();
        check("rdy_hold_req", {35'd0, lb_if.lbuffer_mem_req_out}, 36'd1);
        check("rdy_hold_state", {34'd0, dbg_state}, 36'd1);
        rdy = 1'b1;
        tick();
        exp_q.push_back({4'd3, 32'hDEADBEEF});
        serve(32'hDEADBEEF, 32'h100, 2'd2);
        tick();
        check("lw_cdb_pulse_end", {35'd0, lb_if.lbuffer_cdb_en_out}, 36'd0);

        // sign/zero extension, results in enqueue order
        enqueue(32'h200, 4'd4, OP_LB);
        enqueue(32'h201, 4'd5, OP_LBU);
        enqueue(32'h202, 4'd6, OP_LH);
        enqueue(32'h204, 4'd7, OP_LHU);
        exp_q.push_back({4'd4, 32'hFFFFFFF0});
        exp_q.push_back({4'd5, 32'h000000F0});
        exp_q.push_back({4'd6, 32'hFFFF80F0});
        exp_q.push_back({4'd7, 32'h000080F0});
        serve(32'h000080F0, 32'h200, 2'd0);
        serve(32'h000080F0, 32'h201, 2'd0);
        serve(32'h000080F0, 32'h202, 2'd1);
        serve(32'h000080F0, 32'h204, 2'd1);
        tick();

        // fill to full with issue blocked, drop a 9th, then drain and wrap
        lb_if.rob_lbuffer_store_clear_in = 1'b0;
        for (int i = 0; i < 8; i++)
            enqueue(32'h300 + 32'(4 * i), 4'(i), OP_LW);
        check("full_set", {35'd0, lb_if.lbuffer_addrunit_full_out}, 36'd1);
        enqueue(32'h3F0, 4'd9, OP_LW);
        check("full_drop_count", {32'd0, dbg_count}, 36'd8);
        check("full_no_req", {35'd0, lb_if.lbuffer_mem_req_out}, 36'd0);
        lb_if.rob_lbuffer_store_clear_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({4'(i), 32'h1000 + 32'(i)});
            serve(32'h1000 + 32'(i), 32'h300 + 32'(4 * i), 2'd2);
        end
        check("full_clear", {35'd0, lb_if.lbuffer_addrunit_full_out}, 36'd0);
        for (int i = 0; i < 3; i++)
            enqueue(32'h380 + 32'(4 * i), 4'(10 + i), OP_LW);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({4'(10 + i), 32'h2000 + 32'(i)});
            serve(32'h2000 + 32'(i), 32'h380 + 32'(4 * i), 2'd2);
        end
        tick();

        // store block holds issue; releasing it requests the head only
        lb_if.rob_lbuffer_store_clear_in = 1'b0;
        enqueue(32'h400, 4'd1, OP_LW);
        enqueue(32'h404, 4'd2, OP_LH);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("blk_no_req", {35'd0, lb_if.lbuffer_mem_req_out}, 36'd0);
        end
        lb_if.rob_lbuffer_store_clear_in = 1'b1;
        tick();
        check("blk_req_head", {4'd0, lb_if.lbuffer_mem_a_out}, {4'd0, 32'h400});
        check("blk_count", {32'd0, dbg_count}, 36'd2);
        exp_q.push_back({4'd1, 32'h00005678});
        exp_q.push_back({4'd2, 32'h00001234});
        serve(32'h00005678, 32'h400, 2'd2);
        serve(32'h00001234, 32'h404, 2'd1);
        tick();

        // flush while WAIT: same-cycle enqueue dropped, late ack swallowed
        enqueue(32'h500, 4'd5, OP_LW);
        tick();
        check("fl_wait", {34'd0, dbg_state}, 36'd1);
        lb_if.rob_lbuffer_rst_in         = 1'b1;
        lb_if.addrunit_lbuffer_en_in     = 1'b1;
        lb_if.addrunit_lbuffer_dest_in   = 4'd9;
        lb_if.addrunit_lbuffer_a_in      = 32'h5F0;
        tick();
        lb_if.rob_lbuffer_rst_in     = 1'b0;
        lb_if.addrunit_lbuffer_en_in = 1'b0;
        check("fl_req_low", {35'd0, lb_if.lbuffer_mem_req_out}, 36'd0);
        check("fl_drain", {34'd0, dbg_state}, 36'd2);
        check("fl_count", {32'd0, dbg_count}, 36'd0);
        tick();
        ack(32'hBAD0BAD0);
        check("fl_idle", {34'd0, dbg_state}, 36'd0);
        tick();
        check("fl_no_cdb", {35'd0, lb_if.lbuffer_cdb_en_out}, 36'd0);
        enqueue(32'h600, 4'd6, OP_LBU);
        exp_q.push_back({4'd6, 32'h000000AB});
        serve(32'h123456AB, 32'h600, 2'd0);
        tick();

        // asynchronous reset between edges while WAIT with a full queue
        lb_if.rob_lbuffer_store_clear_in = 1'b0;
        for (int i = 0; i < 8; i++)
            enqueue(32'h700 + 32'(4 * i), 4'(i), OP_LW);
        lb_if.rob_lbuffer_store_clear_in = 1'b1;
        tick();
        check("ar_req_up", {35'd0, lb_if.lbuffer_mem_req_out}, 36'd1);
        check("ar_full_up", {35'd0, lb_if.lbuffer_addrunit_full_out}, 36'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_req", {35'd0, lb_if.lbuffer_mem_req_out}, 36'd0);
        check("ar_full", {35'd0, lb_if.lbuffer_addrunit_full_out}, 36'd0);
        check("ar_cdb", {35'd0, lb_if.lbuffer_cdb_en_out}, 36'd0);
        check("ar_state", {34'd0, dbg_state}, 36'd0);
        #2;
        rst_n = 1'b1;
        tick();
        ack(32'hCAFEF00D);
        tick();
        check("ar_ack_state", {34'd0, dbg_state}, 36'd0);
        check("ar_ack_count", {32'd0, dbg_count}, 36'd0);
        check("ar_ack_cdb", {35'd0, lb_if.lbuffer_cdb_en_out}, 36'd0);

        tick();
        tick();
        check("exp_q_empty", 36'(exp_q.size()), 36'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
